// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC/fetch FSM with one outstanding request and a 2-entry {pc, instr} FIFO toward decode
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        pcsrc_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fd_valid_o,
    output logic [31:0] fd_pc_o,
    output logic [31:0] fd_pc_plus4_o,
    output logic [31:0] fd_instr_o
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fifo_pc [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [31:0] target;
    logic        push;
    logic        pop;

    assign target        = {branch_target_i[31:2], 2'b00};
    assign imem_req_o    = rst_ni && state == RUN && count < 2'd2;
    assign imem_addr_o   = pc;
    assign push          = state == WAIT && imem_rvalid_i && !pcsrc_i;
    assign pop           = fd_valid_o && !stall_i && !pcsrc_i;
    assign fd_valid_o    = count != 2'd0;
    assign fd_pc_o       = fd_valid_o ? fifo_pc[rd_ptr] : 32'h0;
    assign fd_instr_o    = fd_valid_o ? fifo_instr[rd_ptr] : NOP;
    assign fd_pc_plus4_o = fd_pc_o + 32'd4;

    // Fetch FSM: advances PC on grant, tracks the single outstanding request, drops stale responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            case (state)
                RUN: begin
                    if (imem_req_o && imem_gnt_i) begin
                        pc    <= pcsrc_i ? target : pc + 32'd4;
                        state <= pcsrc_i ? DISCARD : WAIT;
                    end else if (pcsrc_i) begin
                        pc <= target;
                    end
                end
                WAIT: begin
                    if (pcsrc_i) pc <= target;
                    if (pcsrc_i || imem_rvalid_i) state <= (pcsrc_i && !imem_rvalid_i) ? DISCARD : RUN;
                end
                DISCARD: begin
                    if (pcsrc_i) pc <= target;
                    if (imem_rvalid_i) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Decode FIFO: pushes the granted fetch's PC (PC-4) with its data, pops on accept, flushes on redirect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0;
                fifo_instr[i] <= NOP;
            end
        end else if (pcsrc_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc - 32'd4;
                fifo_instr[wr_ptr] <= imem_rdata_i;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed fetch sequences with hand-computed expectations
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] target = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus4;
    logic [31:0] fd_instr;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I4  = 32'h00a0_0113;
    localparam logic [31:0] I8  = 32'h0020_81b3;
    localparam logic [31:0] IZ  = 32'h1234_5678;
    localparam logic [31:0] IW  = 32'h0000_0073;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .stall_i(stall),
        .pcsrc_i(pcsrc),
        .branch_target_i(target),
        .imem_req_o(req),
        .imem_addr_o(addr),
        .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata),
        .fd_valid_o(fd_valid),
        .fd_pc_o(fd_pc),
        .fd_pc_plus4_o(fd_pc_plus4),
        .fd_instr_o(fd_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(fd_valid), 32'd0);
        chk("rst_pc", fd_pc, 32'h0);
        chk("rst_instr", fd_instr, NOP);
        chk("rst_addr", addr, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rel_req", 32'(req), 32'd1);
        chk("rel_addr", addr, 32'h0);

        gnt = 1'b1;
        step();
        chk("t1_wait_req", 32'(req), 32'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = I0;
        step();
        chk("t1_valid", 32'(fd_valid), 32'd1);
        chk("t1_pc", fd_pc, 32'h0);
        chk("t1_pc4", fd_pc_plus4, 32'h4);
        chk("t1_instr", fd_instr, I0);
        chk("t1_addr", addr, 32'h4);

        rvalid = 1'b0; stall = 1'b1; gnt = 1'b1;
        step();
        chk("t2_hold_pc", fd_pc, 32'h0);
        gnt = 1'b0; rvalid = 1'b1; rdata = I4;
        step();
        chk("t2_full_req", 32'(req), 32'd0);
        chk("t2_full_pc", fd_pc, 32'h0);
        rvalid = 1'b0; gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_stall_req", 32'(req), 32'd0);
            chk("t2_stall_addr", addr, 32'h8);
            chk("t2_stall_pc", fd_pc, 32'h0);
            chk("t2_stall_instr", fd_instr, I0);
        end
        stall = 1'b0; gnt = 1'b0;
        step();
        chk("t2_pop_pc", fd_pc, 32'h4);
        chk("t2_pop_instr", fd_instr, I4);
        chk("t2_pop_req", 32'(req), 32'd1);
        chk("t2_pop_addr", addr, 32'h8);
        gnt = 1'b1;
        step();
        chk("t2_empty", 32'(fd_valid), 32'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = I8;
        step();
        chk("t2_pc8", fd_pc, 32'h8);
        chk("t2_pc8_plus4", fd_pc_plus4, 32'hC);
        chk("t2_instr8", fd_instr, I8);
        rvalid = 1'b0;
        step();
        chk("t2_drained", 32'(fd_valid), 32'd0);
        chk("t2_drained_instr", fd_instr, NOP);

        gnt = 1'b1;
        step();
        gnt = 1'b0; pcsrc = 1'b1; target = 32'h0000_0102;
        step();
        chk("t3_discard_req", 32'(req), 32'd0);
        chk("t3_flush", 32'(fd_valid), 32'd0);
        pcsrc = 1'b0; rvalid = 1'b1; rdata = IZ;
        step();
        chk("t3_dropped", 32'(fd_valid), 32'd0);
        chk("t3_req", 32'(req), 32'd1);
        chk("t3_addr", addr, 32'h0000_0100);
        rvalid = 1'b0; gnt = 1'b1;
        step();
        gnt = 1'b0; rvalid = 1'b1; rdata = IZ; stall = 1'b1;
        step();
        chk("t3_pushed_pc", fd_pc, 32'h0000_0100);
        rvalid = 1'b0; pcsrc = 1'b1; target = 32'h0000_0200;
        step();
        chk("t3_flush_valid", 32'(fd_valid), 32'd0);
        chk("t3_flush_addr", addr, 32'h0000_0200);
        pcsrc = 1'b0; stall = 1'b0;

        gnt = 1'b1; pcsrc = 1'b1; target = 32'h0000_0300;
        step();
        chk("t4_discard_req", 32'(req), 32'd0);
        gnt = 1'b0; pcsrc = 1'b0; rvalid = 1'b1; rdata = IZ;
        step();
        chk("t4_dropped", 32'(fd_valid), 32'd0);
        chk("t4_req", 32'(req), 32'd1);
        chk("t4_addr", addr, 32'h0000_0300);
        rvalid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_addr", addr, 32'h0000_0300);
            chk("t5_hold_req", 32'(req), 32'd1);
        end
        pcsrc = 1'b1; target = 32'hFFFF_FFFF;
        step();
        chk("t5_align", addr, 32'hFFFF_FFFC);
        pcsrc = 1'b0; gnt = 1'b1;
        step();
        gnt = 1'b0; rvalid = 1'b1; rdata = IZ;
        step();
        chk("t5_wrap_pc", fd_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_plus4", fd_pc_plus4, 32'h0);
        chk("t5_wrap_addr", addr, 32'h0);
        rvalid = 1'b0;
        step();

        gnt = 1'b1;
        step();
        gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(req), 32'd0);
        chk("t6_rst_addr", addr, 32'h0);
        chk("t6_rst_valid", 32'(fd_valid), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("t6_rel_req", 32'(req), 32'd1);
        chk("t6_rel_addr", addr, 32'h0);
        rvalid = 1'b1; rdata = IZ;
        step();
        chk("t6_ignored", 32'(fd_valid), 32'd0);
        chk("t6_req", 32'(req), 32'd1);
        chk("t6_addr", addr, 32'h0);
        rvalid = 1'b0; gnt = 1'b1;
        step();
        chk("t6_wait_valid", 32'(fd_valid), 32'd0);
        gnt = 1'b0; rvalid = 1'b1; rdata = IW;
        step();
        chk("t6_valid", 32'(fd_valid), 32'd1);
        chk("t6_pc", fd_pc, 32'h0);
        chk("t6_instr", fd_instr, IW);
        rvalid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
